// File: rtl/step_motor_sequencer.sv
// -----------------------------------------------------------------------------
// step_motor_sequencer
//
// Multi-channel stepper phase sequencer. Each channel turns a move command
// (a step count) into a sequence of coil drive patterns, stepping at a
// programmable rate in full- or half-step mode, in either direction. Each
// channel also tracks a signed position and can invert its outputs, so that
// inverting and non-inverting bridge drivers share the same logic.
//
// Ports
//   csi_MCLK_clk    : system clock, all logic on the rising edge
//   rsi_MRST_reset  : synchronous active-high reset
//   wr_en           : register write strobe (one write per cycle)
//   wr_chan         : target channel; values >= CHANNELS are ignored
//   wr_addr         : 0=PERIOD, 1=STEPS, 2=CTRL, 3=POSITION
//   wr_data         : write data, LSB-aligned
//   phase_out       : per channel c, bits [4c+3:4c] = {BY,BX,AY,AX}
//   busy            : channel has steps remaining
//   done            : one-cycle pulse with the last step of a move
//   position        : signed step position, POS_WIDTH bits per channel
// -----------------------------------------------------------------------------
module step_motor_sequencer #(
  parameter int CHANNELS   = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int STEP_WIDTH = 16,
  parameter int POS_WIDTH  = 16
) (
  input  logic                          csi_MCLK_clk,
  input  logic                          rsi_MRST_reset,
  input  logic                          wr_en,
  input  logic [2:0]                    wr_chan,
  input  logic [1:0]                    wr_addr,
  input  logic [31:0]                   wr_data,
  output logic [4*CHANNELS-1:0]         phase_out,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           done,
  output logic [POS_WIDTH*CHANNELS-1:0] position
);

  typedef enum logic [1:0] {
    REG_PERIOD   = 2'd0,
    REG_STEPS    = 2'd1,
    REG_CTRL     = 2'd2,
    REG_POSITION = 2'd3
  } reg_addr_t;

  typedef struct packed {
    logic inv;   // [3] invert all four outputs
    logic half;  // [2] half-step mode
    logic dir;   // [1] 1 = index and position increment
    logic en;    // [0] energise coils and allow motion
  } ctrl_t;

  // Coil pattern per phase index, ordered {AX,AY,BX,BY}.
  function automatic logic [3:0] phase_lut(input logic [2:0] idx);
    logic [3:0] pat;
    unique case (idx)
      3'd0: pat = 4'b1000;
      3'd1: pat = 4'b1010;
      3'd2: pat = 4'b0010;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0100;
      3'd5: pat = 4'b0101;
      3'd6: pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Upper write-data bits are architecturally ignored.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DIV_WIDTH-1:0]  period_q;    // programmed PERIOD
    logic [DIV_WIDTH-1:0]  reload_q;    // PERIOD captured at the last divider reload
    logic [DIV_WIDTH-1:0]  div_q;
    logic [STEP_WIDTH-1:0] remaining_q;
    ctrl_t                 ctrl_q;
    logic [2:0]            index_q;
    logic [POS_WIDTH-1:0]  pos_q;
    logic                  done_q;

    logic                  sel;
    logic                  steps_wr;
    logic                  busy_c;
    logic                  moving;
    logic                  fire;
    logic [2:0]            stride;
    logic [2:0]            index_next;
    logic [POS_WIDTH-1:0]  pos_next;
    logic [3:0]            pat;

    // NOTE: every combinational output gets a value on every path, so no
    // latch can be inferred here.
    always_comb begin
      sel      = wr_en && (wr_chan == 3'(c));
      steps_wr = sel && (wr_addr == REG_STEPS);
      busy_c   = (remaining_q != '0);
      moving   = busy_c && ctrl_q.en;
      // Comparing against the captured period keeps a mid-interval PERIOD
      // write from stranding the divider above its terminal count.
      fire     = moving && (div_q == reload_q);
      // Full-step from an even index first lands on an odd index, then
      // strides by two; half-step always strides by one.
      stride     = (!ctrl_q.half && index_q[0]) ? 3'd2 : 3'd1;
      index_next = ctrl_q.dir ? index_q + stride : index_q - stride;
      pos_next   = ctrl_q.dir ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
        period_q    <= '0;
        reload_q    <= '0;
        div_q       <= '0;
        remaining_q <= '0;
        ctrl_q      <= '0;
        index_q     <= '0;
        pos_q       <= '0;
        done_q      <= 1'b0;
      end else begin
        done_q <= 1'b0;
        // A STEPS write takes priority over a step firing on the same edge.
        if (steps_wr) begin
          remaining_q <= wr_data[STEP_WIDTH-1:0];
          div_q       <= '0;
          reload_q    <= period_q;
        end else if (fire) begin
          index_q     <= index_next;
          pos_q       <= pos_next;
          remaining_q <= remaining_q - STEP_WIDTH'(1);
          div_q       <= '0;
          reload_q    <= period_q;
          done_q      <= (remaining_q == STEP_WIDTH'(1));
        end else if (moving) begin
          div_q <= div_q + DIV_WIDTH'(1);
        end

        if (sel) begin
          case (reg_addr_t'(wr_addr))
            REG_PERIOD:   period_q <= wr_data[DIV_WIDTH-1:0];
            REG_CTRL:     ctrl_q   <= ctrl_t'(wr_data[3:0]);
            REG_POSITION: if (!busy_c) pos_q <= wr_data[POS_WIDTH-1:0];
            default:      ;
          endcase
        end
      end
    end

    // Table order {AX,AY,BX,BY} is reversed onto the {BY,BX,AY,AX} pins.
    assign pat = phase_lut(index_q);
    assign phase_out[4*c +: 4] = ctrl_q.en ? ({pat[0], pat[1], pat[2], pat[3]} ^ {4{ctrl_q.inv}})
                                           : {4{ctrl_q.inv}};
    assign busy[c] = busy_c;
    assign done[c] = done_q;
    assign position[POS_WIDTH*c +: POS_WIDTH] = pos_q;
  end

endmodule

// File: tb/tb_step_motor_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_motor_sequencer
//
// Scoreboard bench: each move command pushes its expected step events
// (edge number, pins, position, busy, done) onto a per-channel queue; a
// monitor pops and compares whenever a channel steps or pulses done.
// -----------------------------------------------------------------------------
module tb_step_motor_sequencer;

  localparam int CH = 4;
  localparam int PW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_chan = '0;
  logic [1:0]        wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic [4*CH-1:0]   phase_out;
  logic [CH-1:0]     busy;
  logic [CH-1:0]     done;
  logic [PW*CH-1:0]  position;

  step_motor_sequencer #(
    .CHANNELS(CH), .DIV_WIDTH(16), .STEP_WIDTH(16), .POS_WIDTH(PW)
  ) dut (
    .csi_MCLK_clk  (clk),
    .rsi_MRST_reset(rst),
    .wr_en         (wr_en),
    .wr_chan       (wr_chan),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .phase_out     (phase_out),
    .busy          (busy),
    .done          (done),
    .position      (position)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp_v, cyc);
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int         edge_n;
    logic [3:0] nib;
    logic [15:0] pos;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t        exp_q [CH][$];
  logic [2:0]  m_idx [CH];
  logic [15:0] m_pos [CH];
  logic        m_en  [CH];
  logic        m_inv [CH];

  function automatic logic [3:0] table_pat(input logic [2:0] idx);  // {AX,AY,BX,BY}
    case (idx)
      3'd0: return 4'b1000;
      3'd1: return 4'b1010;
      3'd2: return 4'b0010;
      3'd3: return 4'b0110;
      3'd4: return 4'b0100;
      3'd5: return 4'b0101;
      3'd6: return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [3:0] nib_of(input logic [2:0] idx, input logic en, input logic inv);
    logic [3:0] t;
    t = table_pat(idx);
    if (!en) return {4{inv}};
    return {t[0], t[1], t[2], t[3]} ^ {4{inv}};
  endfunction

  // Queue n step events starting at edge 'first', 'spacing' edges apart.
  // 'ends' marks the final pushed step as the last step of the move.
  task automatic push_move(input int c, input int n, input int first, input int spacing,
                           input logic dir, input logic half, input logic inv, input logic ends);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      int st;
      st = (!half && m_idx[c][0]) ? 2 : 1;
      m_idx[c] = dir ? m_idx[c] + 3'(st) : m_idx[c] - 3'(st);
      m_pos[c] = dir ? m_pos[c] + 16'd1 : m_pos[c] - 16'd1;
      e.edge_n = first + j * spacing;
      e.nib    = nib_of(m_idx[c], 1'b1, inv);
      e.pos    = m_pos[c];
      e.done   = ends && (j == n - 1);
      e.busy   = !e.done;
      exp_q[c].push_back(e);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < CH; c++) s += exp_q[c].size();
    return s;
  endfunction

  // -------------------------------------------------------------- monitor
  logic        mon_en = 1'b0;
  logic [CH-1:0] prev_busy = '0;
  logic [15:0] prev_pos [CH] = '{default: '0};

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < CH; c++) begin
        logic [15:0] p;
        logic [3:0]  nb;
        exp_t        e;
        p  = position[PW*c +: PW];
        nb = phase_out[4*c +: 4];
        if ((prev_busy[c] && p != prev_pos[c]) || done[c]) begin
          if (exp_q[c].size() == 0) begin
            check($sformatf("ch%0d_unexpected_step", c), 64'(exp_q[c].size()), 64'd1);
          end else begin
            e = exp_q[c].pop_front();
            check($sformatf("ch%0d_step_edge", c), 64'(cyc), 64'(e.edge_n));
            check($sformatf("ch%0d_phase", c), 64'(nb), 64'(e.nib));
            check($sformatf("ch%0d_position", c), 64'(p), 64'(e.pos));
            check($sformatf("ch%0d_busy", c), 64'(busy[c]), 64'(e.busy));
            check($sformatf("ch%0d_done", c), 64'(done[c]), 64'(e.done));
          end
        end
        prev_busy[c] = busy[c];
        prev_pos[c]  = p;
      end
    end
  end

  // ------------------------------------------------------------- drivers
  int wr_edge;  // edge on which the last write was registered

  task automatic drive_wr(input int ch, input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_chan = 3'(ch); wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wr_edge = cyc;
  endtask

  task automatic wr(input int ch, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_wr(ch, a, d);
  endtask

  // Write registered exactly on edge 'target'.
  task automatic wr_at(input int target, input int ch, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    while (cyc < target - 1) @(negedge clk);
    drive_wr(ch, a, d);
    check("write_edge", 64'(wr_edge), 64'(target));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_timeout", 64'(pending()), 64'd0);
  endtask

  localparam logic [1:0] A_PERIOD = 2'd0, A_STEPS = 2'd1, A_CTRL = 2'd2, A_POS = 2'd3;

  // ------------------------------------------------------------ stimulus
  initial begin
    int s, r, a, b;
    logic [4*CH-1:0]  exp_ph;
    logic [PW*CH-1:0] exp_pos;

    for (int c = 0; c < CH; c++) begin
      m_idx[c] = '0; m_pos[c] = '0; m_en[c] = 1'b0; m_inv[c] = 1'b0;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_phase", 64'(phase_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_position", 64'(position), 64'd0);
    mon_en = 1'b1;

    // Half-step reverse on ch0, PERIOD=3, 3 steps.
    wr(0, A_CTRL, 32'h5); m_en[0] = 1'b1;
    @(negedge clk);
    check("ch0_energised_idx0", 64'(phase_out[3:0]), 64'(nib_of(3'd0, 1'b1, 1'b0)));
    wr(0, A_PERIOD, 32'd3);
    wr(0, A_STEPS, 32'd3); s = wr_edge;
    check("ch0_busy_rise", 64'(busy[0]), 64'd1);
    push_move(0, 3, s + 4, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain(200);

    // Full-step forward, inverted, PERIOD=0 on ch1.
    wr(1, A_CTRL, 32'hB); m_en[1] = 1'b1; m_inv[1] = 1'b1;
    wr(1, A_PERIOD, 32'd0);
    wr(1, A_STEPS, 32'd3); s = wr_edge;
    push_move(1, 3, s + 1, 1, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_drain(200);

    // Pause/resume on ch2: 2 of 10 steps, freeze, then 8 more.
    wr(2, A_CTRL, 32'hF); m_en[2] = 1'b1; m_inv[2] = 1'b1;
    wr(2, A_PERIOD, 32'd2);
    wr(2, A_STEPS, 32'd10); s = wr_edge;
    push_move(2, 2, s + 3, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    // Divider has advanced to 1 on the edge the freeze lands.
    wr_at(s + 7, 2, A_CTRL, 32'hE);
    repeat (8) @(negedge clk);
    check("ch2_paused_phase", 64'(phase_out[11:8]), 64'hF);
    check("ch2_paused_busy", 64'(busy[2]), 64'd1);
    check("ch2_paused_position", 64'(position[47:32]), 64'(m_pos[2]));
    wr_at(s + 20, 2, A_CTRL, 32'hF); r = wr_edge;
    push_move(2, 8, r + 2, 3, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_drain(300);

    // Abort on ch1; POSITION writes gated by busy.
    wr(1, A_CTRL, 32'h3); m_inv[1] = 1'b0;
    wr(1, A_PERIOD, 32'd1);
    wr(1, A_STEPS, 32'd6); s = wr_edge;
    push_move(1, 2, s + 2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    wr_at(s + 3, 1, A_POS, 32'h8000);
    wr_at(s + 5, 1, A_STEPS, 32'd0);
    @(negedge clk);
    check("ch1_abort_busy", 64'(busy[1]), 64'd0);
    check("ch1_abort_done", 64'(done[1]), 64'd0);
    check("ch1_abort_position", 64'(position[31:16]), 64'(m_pos[1]));
    repeat (6) @(negedge clk);
    check("ch1_abort_position_hold", 64'(position[31:16]), 64'(m_pos[1]));
    wr(1, A_POS, 32'h8000); m_pos[1] = 16'h8000;
    @(negedge clk);
    check("ch1_position_load", 64'(position[31:16]), 64'h8000);

    // Position wrap on ch3.
    wr(3, A_POS, 32'h7FFF); m_pos[3] = 16'h7FFF;
    wr(3, A_CTRL, 32'h3); m_en[3] = 1'b1;
    wr(3, A_STEPS, 32'd1); s = wr_edge;
    push_move(3, 1, s + 1, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain(100);
    check("ch3_wrap", 64'(position[63:48]), 64'h8000);

    // Concurrent moves; out-of-range channel writes are ignored.
    wr(0, A_PERIOD, 32'd1);
    wr(3, A_PERIOD, 32'd4);
    wr(0, A_STEPS, 32'd4); a = wr_edge;
    push_move(0, 4, a + 2, 2, 1'b0, 1'b1, 1'b0, 1'b1);
    wr(3, A_STEPS, 32'd3); b = wr_edge;
    push_move(3, 3, b + 5, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    wr_at(a + 3, 7, A_STEPS, 32'd5);
    wr_at(a + 5, 7, A_CTRL, 32'h0);
    wait_drain(300);

    exp_ph = '0; exp_pos = '0;
    for (int c = 0; c < CH; c++) begin
      exp_ph[4*c +: 4]   = nib_of(m_idx[c], m_en[c], m_inv[c]);
      exp_pos[PW*c +: PW] = m_pos[c];
    end
    check("final_phase", 64'(phase_out), 64'(exp_ph));
    check("final_position", 64'(position), 64'(exp_pos));
    check("final_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
